// File: rtl/posit_encode_pipe.sv
// posit<8,0> encoder back end: normalizes a <2.10> product with its scale sum,
// builds regime + fraction, rounds nearest-even on the bit string, applies specials.
module posit_encode_pipe #(
    parameter int PIPE_STAGES = 3
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        IN_VALID,
    output logic        IN_READY,
    input  logic        SIGN,
    input  logic        ZERO,
    input  logic        NAR,
    input  logic [4:0]  SCALE,
    input  logic [11:0] FRAC,
    output logic        OUT_VALID,
    input  logic        OUT_READY,
    output logic [7:0]  POSIT
);

    generate
        if (PIPE_STAGES != 3) begin : g_bad_depth
            $error("posit_encode_pipe supports PIPE_STAGES == 3 only");
        end
    endgenerate

    // valid bits, one per stage
    logic [3:1] vld_q, vld_d;
    logic       s1_adv, s2_adv, s3_adv;

    // stage 1: normalized mantissa and regime exponent
    logic              s1_sign_q, s1_zero_q, s1_nar_q;
    logic              s1_sign_d, s1_zero_d, s1_nar_d;
    logic signed [5:0] s1_k_q, s1_k_d;
    logic [9:0]        s1_f_q, s1_f_d;
    logic              s1_st_q, s1_st_d;

    // stage 2: rounded, clamped 7-bit magnitude
    logic              s2_sign_q, s2_zero_q, s2_nar_q;
    logic              s2_sign_d, s2_zero_d, s2_nar_d;
    logic [6:0]        s2_mag_q, s2_mag_d;

    // stage 3: final posit word
    logic [7:0]        s3_posit_q, s3_posit_d;

    // a stage may take new data when it is empty or its contents move on
    always_comb begin
        s3_adv   = !vld_q[3] || OUT_READY;
        s2_adv   = !vld_q[2] || s3_adv;
        s1_adv   = !vld_q[1] || s2_adv;
        IN_READY = s1_adv;
        vld_d    = vld_q;
        if (s1_adv) vld_d[1] = IN_VALID;
        if (s2_adv) vld_d[2] = vld_q[1];
        if (s3_adv) vld_d[3] = vld_q[2];
    end

    always_comb begin
        s1_sign_d = s1_sign_q;
        s1_zero_d = s1_zero_q;
        s1_nar_d  = s1_nar_q;
        s1_k_d    = s1_k_q;
        s1_f_d    = s1_f_q;
        s1_st_d   = s1_st_q;
        if (IN_VALID && s1_adv) begin
            s1_sign_d = SIGN;
            s1_zero_d = ZERO;
            s1_nar_d  = NAR;
            if (FRAC[11]) begin
                s1_k_d  = $signed({SCALE[4], SCALE}) + 6'sd1;
                s1_f_d  = FRAC[10:1];
                s1_st_d = FRAC[0];
            end else begin
                s1_k_d  = $signed({SCALE[4], SCALE});
                s1_f_d  = FRAC[9:0];
                s1_st_d = 1'b0;
            end
        end
    end

    // regime+fraction laid out MSB-first in a wide string; top 7 bits are the
    // magnitude, the next bit is guard, everything below folds into sticky
    logic [26:0] fs, str;
    logic [2:0]  kpos, kneg;
    logic [6:0]  mag_raw, mag_rnd;
    logic        guard, sticky, rnd_up;
    logic [7:0]  mag_sum;

    always_comb begin
        fs      = {s1_f_q, s1_st_q, 16'b0};
        kpos    = s1_k_q[2:0];
        kneg    = 3'(-s1_k_q);
        if (!s1_k_q[5])
            str = ~({27{1'b1}} >> (4'(kpos) + 4'd1)) | (fs >> (4'(kpos) + 4'd2));
        else
            str = (27'd1 << (5'd26 - 5'(kneg))) | (fs >> (4'(kneg) + 4'd1));
        mag_raw = str[26:20];
        guard   = str[19];
        sticky  = |str[18:0];
        rnd_up  = guard && (sticky || mag_raw[0]);
        mag_sum = {1'b0, mag_raw} + {7'b0, rnd_up};
        if (mag_sum[7])
            mag_rnd = 7'h7F;
        else if (mag_sum[6:0] == 7'h00)
            mag_rnd = 7'h01;
        else
            mag_rnd = mag_sum[6:0];
    end

    always_comb begin
        s2_sign_d = s2_sign_q;
        s2_zero_d = s2_zero_q;
        s2_nar_d  = s2_nar_q;
        s2_mag_d  = s2_mag_q;
        if (vld_q[1] && s2_adv) begin
            s2_sign_d = s1_sign_q;
            s2_zero_d = s1_zero_q;
            s2_nar_d  = s1_nar_q;
            if (s1_k_q > 6'sd6)
                s2_mag_d = 7'h7F;
            else if (s1_k_q < -6'sd6)
                s2_mag_d = 7'h01;
            else
                s2_mag_d = mag_rnd;
        end
    end

    always_comb begin
        s3_posit_d = s3_posit_q;
        if (vld_q[2] && s3_adv) begin
            if (s2_nar_q)
                s3_posit_d = 8'h80;
            else if (s2_zero_q)
                s3_posit_d = 8'h00;
            else if (s2_sign_q)
                s3_posit_d = ~{1'b0, s2_mag_q} + 8'd1;
            else
                s3_posit_d = {1'b0, s2_mag_q};
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            vld_q      <= '0;
            s1_sign_q  <= 1'b0;
            s1_zero_q  <= 1'b0;
            s1_nar_q   <= 1'b0;
            s1_k_q     <= '0;
            s1_f_q     <= '0;
            s1_st_q    <= 1'b0;
            s2_sign_q  <= 1'b0;
            s2_zero_q  <= 1'b0;
            s2_nar_q   <= 1'b0;
            s2_mag_q   <= '0;
            s3_posit_q <= '0;
        end else begin
            vld_q      <= vld_d;
            s1_sign_q  <= s1_sign_d;
            s1_zero_q  <= s1_zero_d;
            s1_nar_q   <= s1_nar_d;
            s1_k_q     <= s1_k_d;
            s1_f_q     <= s1_f_d;
            s1_st_q    <= s1_st_d;
            s2_sign_q  <= s2_sign_d;
            s2_zero_q  <= s2_zero_d;
            s2_nar_q   <= s2_nar_d;
            s2_mag_q   <= s2_mag_d;
            s3_posit_q <= s3_posit_d;
        end
    end

    assign OUT_VALID = vld_q[3];
    assign POSIT     = s3_posit_q;

endmodule

// File: tb/tb_posit_encode_pipe.sv
// Bench for posit_encode_pipe: directed vectors, bit-serial posit encoder model,
// scoreboard with latency/hold/backpressure/reset checks.
module tb_posit_encode_pipe;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        IN_VALID = 1'b0;
    logic        IN_READY;
    logic        SIGN = 1'b0, ZERO = 1'b0, NAR = 1'b0;
    logic [4:0]  SCALE = '0;
    logic [11:0] FRAC = '0;
    logic        OUT_VALID;
    logic        OUT_READY = 1'b1;
    logic [7:0]  POSIT;

    posit_encode_pipe #(.PIPE_STAGES(3)) dut (
        .CLK(CLK), .RST(RST), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
        .SIGN(SIGN), .ZERO(ZERO), .NAR(NAR), .SCALE(SCALE), .FRAC(FRAC),
        .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY), .POSIT(POSIT)
    );

    always #5 CLK = ~CLK;

    typedef struct {bit s; bit z; bit n; int sc; int fr; logic [7:0] e;} vec_t;
    typedef struct {logic [7:0] exp; int acc; bit lat;} sb_t;

    int    errors = 0;
    int    checks = 0;
    int    cyc = 0;
    int    got = 0;
    bit    lat_mode = 1'b1;
    bit    held_v = 1'b0;
    logic [7:0] held_p = '0;
    sb_t   sbq[$];
    vec_t  vt[19];

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Encodes value = frac/1024 * 2^scale by emitting the posit bit string one
    // bit at a time, then rounds that string to 7 bits nearest-even.
    function automatic logic [7:0] model(input bit s, input bit z, input bit n,
                                         input int scale, input int frac);
        int k, fb, mg;
        bit g, r;
        bit bits[$];
        if (n) return 8'h80;
        if (z) return 8'h00;
        k  = scale;
        fb = 10;
        if (frac >= 2048) begin k = k + 1; fb = 11; end
        if (k > 6) mg = 127;
        else if (k < -6) mg = 1;
        else begin
            if (k >= 0) begin
                for (int i = 0; i <= k; i++) bits.push_back(1'b1);
                bits.push_back(1'b0);
            end else begin
                for (int i = 0; i < -k; i++) bits.push_back(1'b0);
                bits.push_back(1'b1);
            end
            for (int i = fb - 1; i >= 0; i--) bits.push_back(((frac >> i) & 1) != 0);
            while (bits.size() < 9) bits.push_back(1'b0);
            mg = 0;
            for (int i = 0; i < 7; i++) mg = mg * 2 + int'(bits[i]);
            g = bits[7];
            r = 1'b0;
            for (int i = 8; i < bits.size(); i++) r = r | bits[i];
            if (g && (r || (mg % 2 == 1))) mg++;
            if (mg > 127) mg = 127;
            if (mg < 1) mg = 1;
        end
        return s ? 8'(256 - mg) : 8'(mg);
    endfunction

    task automatic drive(input vec_t v);
        SIGN     = v.s;
        ZERO     = v.z;
        NAR      = v.n;
        SCALE    = 5'(v.sc);
        FRAC     = 12'(v.fr);
        IN_VALID = 1'b1;
    endtask

    task automatic push(input vec_t v);
        sb_t e;
        e.exp = model(v.s, v.z, v.n, v.sc, v.fr);
        e.acc = cyc;
        e.lat = lat_mode;
        sbq.push_back(e);
    endtask

    // offer one beat; returns once it will be taken at the next rising edge
    task automatic send(input vec_t v);
        int t;
        @(posedge CLK); #2;
        drive(v);
        #1;
        t = 0;
        while (!IN_READY && t < 50) begin
            @(posedge CLK); #3;
            t++;
        end
        chk("send_accept", {31'b0, IN_READY}, 1);
        push(v);
    endtask

    task automatic idle();
        @(posedge CLK); #2;
        IN_VALID = 1'b0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (sbq.size() > 0 && t < 100) begin
            @(posedge CLK);
            t++;
        end
        @(negedge CLK); #1;
        chk("drain", sbq.size(), 0);
    endtask

    // output checker: ordering/value, latency, hold-under-backpressure, spurious
    always @(negedge CLK) begin
        sb_t e;
        if (!RST) begin
            if (OUT_VALID && sbq.size() == 0) begin
                chk("spurious_out", {31'b0, OUT_VALID}, 0);
            end else if (OUT_VALID && OUT_READY) begin
                e = sbq.pop_front();
                chk("posit", {24'b0, POSIT}, {24'b0, e.exp});
                if (e.lat) chk("latency", cyc - e.acc, 3);
                got++;
            end
            if (OUT_VALID && !OUT_READY) begin
                if (held_v) chk("hold_stable", {24'b0, POSIT}, {24'b0, held_p});
                held_v = 1'b1;
                held_p = POSIT;
            end else begin
                held_v = 1'b0;
            end
        end else begin
            held_v = 1'b0;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc, g0, seen;
        vt[0]  = '{0, 0, 0,   0, 'h400, 8'h40};
        vt[1]  = '{0, 0, 0,   0, 'h600, 8'h50};
        vt[2]  = '{0, 0, 0,   0, 'h900, 8'h62};
        vt[3]  = '{1, 0, 0,   0, 'h400, 8'hC0};
        vt[4]  = '{0, 0, 0,   0, 'h410, 8'h40};
        vt[5]  = '{0, 0, 0,   0, 'h430, 8'h42};
        vt[6]  = '{0, 0, 0,   0, 'h7F1, 8'h60};
        vt[7]  = '{0, 0, 0,  10, 'h400, 8'h7F};
        vt[8]  = '{0, 0, 0, -10, 'h400, 8'h01};
        vt[9]  = '{0, 1, 0,   3, 'h555, 8'h00};
        vt[10] = '{0, 1, 1,   3, 'h555, 8'h80};
        vt[11] = '{0, 0, 0,  -1, 'h400, 8'h20};
        vt[12] = '{0, 0, 0,   5, 'h400, 8'h7E};
        vt[13] = '{0, 0, 0,  -6, 'h7FF, 8'h02};
        vt[14] = '{1, 0, 0,   0, 'h900, 8'h9E};
        vt[15] = '{0, 0, 0,  -1, 'hC00, 8'h50};
        vt[16] = '{0, 0, 0,   2, 'h500, 8'h72};
        vt[17] = '{0, 0, 0,   6, 'hFFF, 8'h7F};
        vt[18] = '{1, 0, 0, -12, 'h400, 8'hFF};

        // reset state
        repeat (2) @(posedge CLK);
        #2;
        chk("rst_out_valid", {31'b0, OUT_VALID}, 0);
        chk("rst_posit", {24'b0, POSIT}, 0);
        RST = 1'b0;
        #1;
        chk("rst_in_ready", {31'b0, IN_READY}, 1);

        // hand-computed values pin the model
        for (int i = 0; i < 19; i++)
            chk($sformatf("model_pin%0d", i),
                {24'b0, model(vt[i].s, vt[i].z, vt[i].n, vt[i].sc, vt[i].fr)},
                {24'b0, vt[i].e});

        // back-to-back stream, no backpressure
        for (int i = 0; i < 19; i++) send(vt[i]);
        idle();
        drain();

        // sparse traffic with bubbles
        for (int i = 0; i < 6; i++) begin
            send(vt[(i * 5) % 19]);
            idle();
            if (i % 2 == 1) idle();
        end
        drain();

        // backpressure: 3 held, 4th refused, then release
        lat_mode = 1'b0;
        g0  = got;
        acc = 0;
        for (int t = 0; t < 12 && acc < 5; t++) begin
            @(posedge CLK); #2;
            OUT_READY = (t >= 5);
            drive(vt[acc + 1]);
            #1;
            if (t == 3) chk("bp_in_ready_full", {31'b0, IN_READY}, 0);
            if (t == 4) chk("bp_accepted", acc, 3);
            if (IN_READY) begin
                push(vt[acc + 1]);
                acc++;
            end
        end
        idle();
        repeat (3) @(negedge CLK);
        #1;
        chk("bp_one_per_cycle", got - g0, 5);
        drain();
        lat_mode = 1'b1;

        // reset with two beats in flight
        send(vt[1]);
        send(vt[2]);
        idle();
        @(posedge CLK); #2;
        chk("pre_rst_valid", {31'b0, OUT_VALID}, 1);
        RST = 1'b1;
        #1;
        chk("async_rst_valid", {31'b0, OUT_VALID}, 0);
        chk("async_rst_posit", {24'b0, POSIT}, 0);
        sbq.delete();
        repeat (2) @(posedge CLK);
        #2;
        RST = 1'b0;
        seen = 0;
        for (int t = 0; t < 10; t++) begin
            @(negedge CLK);
            if (OUT_VALID) seen++;
        end
        chk("no_stale_after_rst", seen, 0);

        // still functional after reset
        send(vt[14]);
        send(vt[6]);
        idle();
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/posit_encode_pipe.md
Name: posit_encode_pipe

Overview:
- Back end of the posit<8,0> multiply datapath: consumes the scale-sum / fraction-product pair and re-encodes it into an 8-bit posit word.
- Normalizes the <2.10> product, rounds to nearest-even on the encoded bit string, saturates to minpos/maxpos, and applies sign / zero / NaR.
- Three-stage valid/ready pipeline; sits between the multiplier stage and the result register file.

Parameters:
- PIPE_STAGES, 3, fixed pipeline depth; only 3 is supported; any other value is an elaboration error.

Ports:
- CLK       input   1   clock; all state updates on the rising edge.
- RST       input   1   asynchronous reset, active-high.
- IN_VALID  input   1   input beat valid.
- IN_READY  output  1   block can accept an input beat this cycle.
- SIGN      input   1   result sign (XOR of operand signs).
- ZERO      input   1   result is exactly zero.
- NAR       input   1   result is NaR; takes priority over ZERO.
- SCALE     input   5   scale sum, signed integer, legal range -12..12.
- FRAC      input   12  fraction product, <2.10> unsigned fixed point, value in [1.0, 4.0).
- OUT_VALID output  1   output beat valid.
- OUT_READY input   1   downstream accepts the output beat.
- POSIT     output  8   encoded posit<8,0>.

Behaviour:
- Reset: all stage valid bits cleared; OUT_VALID=0, POSIT=8'h00, IN_READY=1 once RST deasserts. Reset mid-operation discards all in-flight beats.
- Handshake: a beat transfers when VALID and READY are both high in the same cycle. POSIT is stable while OUT_VALID=1 and OUT_READY=0.
- Pipeline: a stage advances when the next stage is empty or advancing. IN_READY = !s1_valid | s1_advance, so bubbles collapse. Registered path; IN_READY may depend combinationally on OUT_READY.
- Latency: 3 cycles from input accept to OUT_VALID with no backpressure. Throughput is 1 beat per cycle.
- Capacity: 3 beats held with OUT_READY=0; the 4th is refused (IN_READY=0). No loss or duplication.
- S1, normalize: if FRAC[11]=1, shift right 1 and set k=SCALE+1 (the shifted-out bit feeds sticky); else k=SCALE. Resulting mantissa is 1.f, with f 10 bits plus sticky.
- S2, regime build and clamp:
  - k>6: magnitude = 7'h7F.
  - k<-6: magnitude = 7'h01.
  - k>=0: regime is k+1 ones followed by a zero (terminator dropped at k=6).
  - k<0: regime is -k zeros followed by a one.
  - Fraction bits fill the remaining 7-regime_len positions.
- S2, rounding: round to nearest-even using guard bit, then round-bit OR sticky over all lower bits.
  - A rounding carry may ripple into the regime; this is legal posit behaviour.
  - The final magnitude is clamped to [7'h01, 7'h7F]: never rounds to 0 or to NaR.
- S3, sign and specials:
  - NAR → 8'h80.
  - else ZERO → 8'h00.
  - else SIGN=1 → two's complement of {0, mag}.
  - else {0, mag}.
  - SCALE and FRAC are don't-care when ZERO or NAR is set.
- Inputs outside the legal range are clamped by the k rules above; no error flag.

Test Plan:
- Basic values:
  - SCALE=0, FRAC=12'h400 → POSIT=8'h40, 3 cycles after accept.
  - SCALE=0, FRAC=12'h600 → 8'h50.
- Normalization: SCALE=0, FRAC=12'h900 (2.25) → 8'h62. With SIGN=1, SCALE=0, FRAC=12'h400 → 8'hC0.
- Rounding:
  - FRAC=12'h410 (tie) → 8'h40 (even).
  - FRAC=12'h430 (tie) → 8'h42.
  - FRAC=12'h7F1, SCALE=0 → carry into regime → 8'h60.
- Saturation and specials:
  - SCALE=10 → 8'h7F.
  - SCALE=-10 → 8'h01.
  - ZERO=1 → 8'h00.
  - NAR=1 with ZERO=1 → 8'h80.
- Backpressure: hold OUT_READY=0 and offer 5 beats.
  - IN_READY falls after 3 accepted beats.
  - Release OUT_READY: outputs arrive in order, one per cycle, no drops or repeats.
- Reset: assert RST with 2 beats in flight → OUT_VALID=0 and POSIT=00 immediately (async); no stale beat emerges after release.
